// File: rtl/sd_cmd_seq_if.sv
// Signal bundle between the MCU command registers, sd_cmd_seq and the SPI byte engine.
// SPI handshake: spi_req_o rises with spi_txd_o8 valid and both hold until the cycle in
// which spi_done_i pulses (spi_rxd_i8 valid only in that cycle). The next byte may be
// requested from the cycle after done, so req may stay high across back-to-back bytes;
// a spi_done_i seen while spi_req_o=0 has no effect.
interface sd_cmd_seq_if;
   logic        cmd_start_i;
   logic [5:0]  cmd_idx_i6;
   logic [31:0] cmd_arg_i32;
   logic [6:0]  cmd_crc_i7;
   logic        cmd_busy_o;
   logic        cmd_done_o;
   logic        cmd_timeout_o;
   logic [7:0]  cmd_resp_o8;
   logic        spi_cs_n_o;
   logic        spi_req_o;
   logic [7:0]  spi_txd_o8;
   logic        spi_done_i;
   logic [7:0]  spi_rxd_i8;

   // Sequencer side: consumes MCU command fields, drives the SPI engine.
   modport master (
      input  cmd_start_i, cmd_idx_i6, cmd_arg_i32, cmd_crc_i7,
      output cmd_busy_o, cmd_done_o, cmd_timeout_o, cmd_resp_o8,
      output spi_cs_n_o, spi_req_o, spi_txd_o8,
      input  spi_done_i, spi_rxd_i8
   );

   // Environment side: MCU register file plus SPI byte engine.
   modport slave (
      output cmd_start_i, cmd_idx_i6, cmd_arg_i32, cmd_crc_i7,
      input  cmd_busy_o, cmd_done_o, cmd_timeout_o, cmd_resp_o8,
      input  spi_cs_n_o, spi_req_o, spi_txd_o8,
      output spi_done_i, spi_rxd_i8
   );
endinterface

// File: rtl/sd_cmd_seq.sv
// Issues one SD command in SPI mode: pre-fill bytes, 6-byte frame, R1 poll, CS release.
// Optional feature macro SD_CRC7_EN: generate the frame CRC7 in hardware instead of cmd_crc_i7.
module sd_cmd_seq #(
   parameter int PRE_BYTES  = 1,
   parameter int POLL_MAX   = 8,
   parameter int POST_BYTES = 1
) (
   input  logic         clk_i,
   input  logic         mcu_rst_i,
   sd_cmd_seq_if.master bus,
   output logic [2:0]   dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_SEND = 3'd2,
      S_POLL = 3'd3,
      S_POST = 3'd4,
      S_DONE = 3'd5
   } state_t;

   localparam logic [7:0] PRE_LAST  = 8'(PRE_BYTES - 1);
   localparam logic [7:0] POLL_LAST = 8'(POLL_MAX - 1);
   localparam logic [7:0] POST_LAST = 8'(POST_BYTES - 1);

   state_t      r_state, w_state_nxt;
   logic [7:0]  r_cnt, w_cnt_nxt;
   logic [5:0]  r_idx, w_idx_nxt;
   logic [31:0] r_arg, w_arg_nxt;
   logic [6:0]  r_crc, w_crc_nxt;
   logic        r_busy, w_busy_nxt;
   logic        r_done, w_done_nxt;
   logic        r_timeout, w_timeout_nxt;
   logic [7:0]  r_resp, w_resp_nxt;
   logic        r_cs_n, w_cs_n_nxt;
   logic        r_req, w_req_nxt;
   logic [7:0]  r_txd, w_txd_nxt;
   logic [6:0]  w_crc_lat;
   logic        w_byte_done;
   logic        w_poll_exit;

   function automatic logic [7:0] frame_byte(input logic [5:0]  idx,
                                             input logic [31:0] arg,
                                             input logic [6:0]  crc,
                                             input logic [2:0]  n);
      logic [7:0] b;
      case (n)
         3'd0:    b = {2'b01, idx};
         3'd1:    b = arg[31:24];
         3'd2:    b = arg[23:16];
         3'd3:    b = arg[15:8];
         3'd4:    b = arg[7:0];
         3'd5:    b = {crc, 1'b1};
         default: b = 8'hFF;
      endcase
      return b;
   endfunction

`ifdef SD_CRC7_EN
   // CRC7 (x^7+x^3+1, init 0) over frame bytes 0..4, evaluated once at latch time so
   // byte 5 is ready as soon as the frame reaches it.
   function automatic logic [6:0] crc7_calc(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = 7'd0;
      for (int i = 39; i >= 0; i--) begin
         fb = c[6] ^ d[i];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   assign w_crc_lat = crc7_calc({2'b01, bus.cmd_idx_i6, bus.cmd_arg_i32});
`else
   assign w_crc_lat = bus.cmd_crc_i7;
`endif

   assign w_byte_done = bus.spi_done_i & r_req;

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_idx_nxt     = r_idx;
      w_arg_nxt     = r_arg;
      w_crc_nxt     = r_crc;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_timeout_nxt = r_timeout;
      w_resp_nxt    = r_resp;
      w_cs_n_nxt    = r_cs_n;
      w_req_nxt     = r_req;
      w_txd_nxt     = r_txd;
      w_poll_exit   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (bus.cmd_start_i) begin
               w_idx_nxt     = bus.cmd_idx_i6;
               w_arg_nxt     = bus.cmd_arg_i32;
               w_crc_nxt     = w_crc_lat;
               w_busy_nxt    = 1'b1;
               w_timeout_nxt = 1'b0;
               w_resp_nxt    = 8'hFF;
               w_cs_n_nxt    = 1'b0;
               w_req_nxt     = 1'b1;
               w_cnt_nxt     = 8'd0;
               if (PRE_BYTES == 0) begin
                  w_state_nxt = S_SEND;
                  w_txd_nxt   = frame_byte(bus.cmd_idx_i6, bus.cmd_arg_i32, w_crc_lat, 3'd0);
               end else begin
                  w_state_nxt = S_PRE;
                  w_txd_nxt   = 8'hFF;
               end
            end
         end
         S_PRE: begin
            if (w_byte_done) begin
               if (r_cnt == PRE_LAST) begin
                  w_state_nxt = S_SEND;
                  w_cnt_nxt   = 8'd0;
                  w_txd_nxt   = frame_byte(r_idx, r_arg, r_crc, 3'd0);
               end else begin
                  w_cnt_nxt = r_cnt + 8'd1;
               end
            end
         end
         S_SEND: begin
            if (w_byte_done) begin
               if (r_cnt == 8'd5) begin
                  w_state_nxt = S_POLL;
                  w_cnt_nxt   = 8'd0;
                  w_txd_nxt   = 8'hFF;
               end else begin
                  w_cnt_nxt = r_cnt + 8'd1;
                  w_txd_nxt = frame_byte(r_idx, r_arg, r_crc, r_cnt[2:0] + 3'd1);
               end
            end
         end
         S_POLL: begin
            if (w_byte_done) begin
               // An R1 on the final permitted poll byte still wins over the timeout.
               if (!bus.spi_rxd_i8[7]) begin
                  w_resp_nxt  = bus.spi_rxd_i8;
                  w_poll_exit = 1'b1;
               end else if (r_cnt == POLL_LAST) begin
                  w_resp_nxt    = 8'hFF;
                  w_timeout_nxt = 1'b1;
                  w_poll_exit   = 1'b1;
               end else if (r_cnt != 8'hFF) begin
                  w_cnt_nxt = r_cnt + 8'd1;
               end
            end
            if (w_poll_exit) begin
               w_cs_n_nxt = 1'b1;
               w_cnt_nxt  = 8'd0;
               w_txd_nxt  = 8'hFF;
               if (POST_BYTES == 0) begin
                  w_req_nxt   = 1'b0;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_POST;
               end
            end
         end
         S_POST: begin
            if (w_byte_done) begin
               if (r_cnt == POST_LAST) begin
                  w_req_nxt   = 1'b0;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_DONE;
               end else begin
                  w_cnt_nxt = r_cnt + 8'd1;
               end
            end
         end
         S_DONE: begin
            // Busy stays high through the done cycle so a start landing here is dropped.
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_cs_n_nxt  = 1'b1;
            w_req_nxt   = 1'b0;
            w_txd_nxt   = 8'hFF;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge mcu_rst_i) begin
      if (mcu_rst_i) begin
         r_state   <= S_IDLE;
         r_cnt     <= 8'd0;
         r_idx     <= 6'd0;
         r_arg     <= 32'd0;
         r_crc     <= 7'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
         r_resp    <= 8'hFF;
         r_cs_n    <= 1'b1;
         r_req     <= 1'b0;
         r_txd     <= 8'hFF;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_idx     <= w_idx_nxt;
         r_arg     <= w_arg_nxt;
         r_crc     <= w_crc_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_timeout <= w_timeout_nxt;
         r_resp    <= w_resp_nxt;
         r_cs_n    <= w_cs_n_nxt;
         r_req     <= w_req_nxt;
         r_txd     <= w_txd_nxt;
      end
   end

   assign bus.cmd_busy_o    = r_busy;
   assign bus.cmd_done_o    = r_done;
   assign bus.cmd_timeout_o = r_timeout;
   assign bus.cmd_resp_o8   = r_resp;
   assign bus.spi_cs_n_o    = r_cs_n;
   assign bus.spi_req_o     = r_req;
   assign bus.spi_txd_o8    = r_txd;
   assign dbg_state_o       = r_state;

endmodule
